mult_ctrl_one: RTL and testbench

Sequencing controller for the 8-bit radix-2 Booth shift-add multiplier datapath (mult_dp_one).
- Accepts a start request and issues the load/init cycle.
- Runs N_BITS Booth iterations, steering add/subtract/pass from the datapath's {Ao,Qo} status bits.
- Captures the 16-bit product into a held register and raises a one-cycle done pulse.
- Sits between the requesting block (operands on Abus/Bbus) and the datapath control pins.

---
 rtl/mult_ctrl_one.sv | 121 ++++++++++++
 tb/tb_mult_ctrl_one.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl_one.sv
// Sequencer for the radix-2 Booth shift-add multiplier datapath (mult_dp_one):
// load/init on start, N_BITS Booth iterations, then capture of the 2*N_BITS product.
module mult_ctrl_one #(
  parameter int N_BITS = 8,
  parameter int CNT_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        Ao,
  input  logic                        Qo,
  input  logic signed [2*N_BITS-1:0]  Rbus,
  output logic                        initP,
  output logic                        initQ,
  output logic                        ldA,
  output logic                        ldB,
  output logic                        ldP,
  output logic                        ldQ,
  output logic                        one_selB,
  output logic                        zero_selB,
  output logic                        busy,
  output logic                        done,
  output logic signed [2*N_BITS-1:0]  product
);

  typedef enum logic [1:0] {IDLE, ITER, CAPT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_iter;
  logic             capture;

  // Booth recoding of {Ao,Qo}: 10 -> subtract B, 01 -> add B, else pass.
  function automatic logic [1:0] booth_sel(input logic a0, input logic q0);
    logic [1:0] sel;
    sel = 2'b00;
    case ({a0, q0})
      2'b10:   sel = 2'b10;
      2'b01:   sel = 2'b01;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

  assign last_iter = (cnt == CNT_W'(N_BITS - 1));
  assign capture   = (state == CAPT) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = ITER;
      end
      ITER: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_iter) begin
          state_nxt = CAPT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CAPT: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    initP     = 1'b0;
    initQ     = 1'b0;
    ldA       = 1'b0;
    ldB       = 1'b0;
    ldP       = 1'b0;
    ldQ       = 1'b0;
    one_selB  = 1'b0;
    zero_selB = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start && !abort) begin
          initP = 1'b1;
          initQ = 1'b1;
          ldA   = 1'b1;
          ldB   = 1'b1;
        end
      end
      ITER: begin
        ldP                   = 1'b1;
        ldQ                   = 1'b1;
        {one_selB, zero_selB} = booth_sel(Ao, Qo);
      end
      default: ;
    endcase
  end

  // Rbus is only valid during CAPT; Areg free-shifts afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= capture;
      if (capture) product <= Rbus;
    end
  end

endmodule

// File: tb/tb_mult_ctrl_one.sv
// Bench for mult_ctrl_one driving a behavioural Booth datapath model.
module tb_mult_ctrl_one;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic signed [N-1:0] Abus, Bbus;
  logic Ao, Qo;
  logic signed [2*N-1:0] Rbus, product;
  logic initP, initQ, ldA, ldB, ldP, ldQ, one_selB, zero_selB, busy, done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_ctrl_one #(.N_BITS(N), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .Ao(Ao), .Qo(Qo),
    .Rbus(Rbus), .initP(initP), .initQ(initQ), .ldA(ldA), .ldB(ldB),
    .ldP(ldP), .ldQ(ldQ), .one_selB(one_selB), .zero_selB(zero_selB),
    .busy(busy), .done(done), .product(product)
  );

  // Datapath model: Preg/Areg/Q arithmetic shift, Breg multiplicand.
  logic signed [N-1:0] P, A, B, sum;
  logic Q;
  always_comb begin
    sum = P;
    if (zero_selB)     sum = P + B;
    else if (one_selB) sum = P - B;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      P <= '0; A <= '0; B <= '0; Q <= 1'b0;
    end else begin
      if (ldB) B <= Bbus;
      if (initP)    P <= '0;
      else if (ldP) P <= {sum[N-1], sum[N-1:1]};
      if (initQ)    Q <= 1'b0;
      else if (ldQ) Q <= A[0];
      if (ldA) A <= Abus;
      else     A <= {(ldP ? sum[0] : P[0]), A[N-1:1]};
    end
  end
  assign Ao   = A[0];
  assign Qo   = Q;
  assign Rbus = {P, A};

  typedef struct {
    logic signed [N-1:0] a;
    logic signed [N-1:0] b;
    logic [2*N-1:0]      exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entry and exit: 1 time unit after a rising edge, controller idle.
  task automatic run_op(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                        input logic [2*N-1:0] exp);
    int bad;
    bad = 0;
    Abus = a; Bbus = b; start = 1'b1; abort = 1'b0;
    #1;
    chk("start_loads", {27'd0, ldA, ldB, initP, initQ, busy}, {27'd0, 4'b1111, 1'b0});
    step();
    start = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      if (!busy || !ldP || !ldQ || ldA || initP) bad++;
      if (one_selB !== (Ao & ~Qo))  bad++;
      if (zero_selB !== (~Ao & Qo)) bad++;
      if (one_selB && zero_selB)    bad++;
      step();
    end
    chk("iter_ctrl", bad, 0);
    chk("capt_cycle", {27'd0, busy, ldP, ldQ, one_selB | zero_selB, done},
        {27'd0, 5'b10000});
    step();
    chk("done_cycle", {30'd0, done, busy}, {30'd0, 2'b10});
    chk("product", {16'd0, product}, {16'd0, exp});
    step();
    chk("done_pulse_end", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int ndone, badld, dcnt;
    logic [2*N-1:0] prods[4];
    logic [2*N-1:0] prev;

    vecs[0] = '{8'sd3,    8'sd5,    16'h000F};
    vecs[1] = '{-8'sd7,   -8'sd6,   16'h002A};
    vecs[2] = '{-8'sd128, 8'sd3,    16'hFE80};
    vecs[3] = '{8'sd127,  -8'sd1,   16'hFF81};
    vecs[4] = '{8'sd0,    -8'sd5,   16'h0000};
    vecs[5] = '{-8'sd1,   -8'sd1,   16'h0001};
    vecs[6] = '{8'sd100,  -8'sd100, 16'hD8F0};
    vecs[7] = '{-8'sd128, 8'sd127,  16'hC080};

    rst = 1'b1; start = 1'b0; abort = 1'b0; Abus = '0; Bbus = '0;
    #12;
    chk("reset_state", {16'd0, product}, 32'd0);
    chk("reset_ctrl", {22'd0, initP, initQ, ldA, ldB, ldP, ldQ, one_selB, zero_selB, busy, done},
        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp);
    prev = vecs[7].exp;

    // start together with abort in IDLE: nothing happens
    Abus = 8'sd4; Bbus = 8'sd4; start = 1'b1; abort = 1'b1;
    #1;
    chk("abort_idle_loads", {28'd0, ldA, ldB, initP, initQ}, 32'd0);
    step();
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; abort = 1'b0;
    step();

    // start held high: back-to-back acceptance in each done cycle only
    ndone = 0; badld = 0;
    for (int c = 0; c < 40; c++) begin
      start = (c < 30);
      if (c == 0) begin Abus = 8'sd3; Bbus = 8'sd5; end
      else        begin Abus = 8'sd2; Bbus = 8'sd2; end
      #1;
      if (c < 30 && ldA !== (c == 0 || c == 10 || c == 20)) badld++;
      if (done) begin
        if (ndone < 4) prods[ndone] = product;
        ndone++;
      end
      step();
    end
    chk("held_start_loads", badld, 0);
    chk("held_start_ndone", ndone, 3);
    chk("held_start_p0", {16'd0, prods[0]}, 32'h000F);
    chk("held_start_p1", {16'd0, prods[1]}, 32'h0004);
    chk("held_start_p2", {16'd0, prods[2]}, 32'h0004);
    prev = 16'h0004;

    // abort in the 4th ITER cycle of 9*9
    Abus = 8'sd9; Bbus = 8'sd9; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    abort = 1'b1;
    #1;
    chk("abort_cycle_ctrl", {29'd0, busy, ldP, ldQ}, {29'd0, 3'b111});
    step();
    abort = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy) dcnt++;
      step();
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_product_kept", {16'd0, product}, {16'd0, prev});
    run_op(8'sd2, 8'sd3, 16'h0006);

    // asynchronous reset mid-ITER
    Abus = 8'sd9; Bbus = 8'sd9; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_mid_product", {16'd0, product}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_release_ctrl",
        {22'd0, initP, initQ, ldA, ldB, ldP, ldQ, one_selB, zero_selB, busy, done}, 32'd0);
    step();
    run_op(-8'sd7, -8'sd6, 16'h002A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
